// File: rtl/nios_qsys_cpu_0_oci_dct_packer.sv
// Trace-atom packer: shifts 2-bit OCI trace atoms into a 30-bit buffer.
// Up to 15 atoms are collected, then the buffer is emitted as a 34-bit
// frame {count, buffer} over a valid/ready handshake.
// A flush or test_ending request emits a partial frame instead.
module nios_qsys_cpu_0_oci_dct_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        atom_valid,
   input  logic [1:0]  atom,
   output logic        atom_ready,
   input  logic        flush,
   input  logic        test_ending,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        frame_valid,
   output logic [33:0] frame_data,
   input  logic        frame_ready
);

   localparam logic [3:0] FullCount = 4'd15;

   logic [29:0] r_dct_buffer;
   logic [3:0]  r_dct_count;
   logic        r_frame_valid;
   logic [33:0] r_frame_data;
   logic        r_flush_pend;

   logic        w_accept;
   logic [29:0] w_next_buf;
   logic [3:0]  w_next_cnt;
   logic        w_flush_req;
   logic        w_xfer_want;
   logic        w_xfer_allow;
   logic        w_xfer;
   logic        w_flush_pend_d;

   // FULL is the only state that refuses atoms; the other states are implied by the count.
   assign atom_ready  = (r_dct_count != FullCount);
   assign dct_buffer  = r_dct_buffer;
   assign dct_count   = r_dct_count;
   assign frame_valid = r_frame_valid;
   assign frame_data  = r_frame_data;

   // Compute the buffer contents after this cycle's atom, and decide whether a frame leaves.
   always_comb begin
      w_accept     = atom_valid && atom_ready;
      w_next_buf   = r_dct_buffer;
      w_next_cnt   = r_dct_count;
      if (w_accept) begin
         w_next_buf = {r_dct_buffer[27:0], atom};
         w_next_cnt = r_dct_count + 4'd1;
      end
      w_flush_req  = r_flush_pend || flush || test_ending;
      w_xfer_want  = (w_next_cnt == FullCount) || (w_flush_req && (w_next_cnt != 4'd0));
      w_xfer_allow = !r_frame_valid || frame_ready;
      w_xfer       = w_xfer_want && w_xfer_allow;
   end

   // Track a pending flush. A flush of an empty buffer is dropped, not emitted.
   always_comb begin
      w_flush_pend_d = r_flush_pend;
      if (w_xfer) begin
         w_flush_pend_d = 1'b0;
      end else if (w_flush_req && (w_next_cnt == 4'd0)) begin
         w_flush_pend_d = 1'b0;
      end else if (flush || test_ending) begin
         w_flush_pend_d = 1'b1;
      end
   end

   // Hold the accumulation buffer; it restarts from zero when a frame is handed off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dct_buffer <= '0;
         r_dct_count  <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_flush_pend <= w_flush_pend_d;
         if (w_xfer) begin
            r_dct_buffer <= '0;
            r_dct_count  <= '0;
         end else begin
            r_dct_buffer <= w_next_buf;
            r_dct_count  <= w_next_cnt;
         end
      end
   end

   // Output frame slot: load on transfer, drop when consumed, stay stable while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_valid <= 1'b0;
         r_frame_data  <= '0;
      end else if (w_xfer) begin
         r_frame_valid <= 1'b1;
         r_frame_data  <= {w_next_cnt, w_next_buf};
      end else if (frame_ready) begin
         r_frame_valid <= 1'b0;
      end
   end

endmodule
